onehot_request_encoder: RTL and testbench
=========================================

Name: onehot_request_encoder

Overview:
- Reverse direction of the 4-to-16 register-select decoder: collects 16 one-hot request lines and emits one 4-bit index at a time over a valid/ready handshake.
- Requests are captured into a sticky pending register and arbitrated round-robin (or fixed priority). The chosen index is held stable until the consumer accepts it.
- Sits between the control-unit request sources and any consumer of a 4-bit selector, e.g. the register-file write-select path.

Parameters:
- N_REQ, 16, number of request lines; must equal 2**IDX_W.
- IDX_W, 4, index width.
- ROUND_ROBIN, 1, 1 = rotating priority starting at the last grant + 1; 0 = fixed priority, lowest index wins.
- CNT_W, 8, width of the saturating coalesce counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  N_REQ  request pulses or levels; any number of bits may be set per cycle.
- idx  output  IDX_W  encoded index of the current grant.
- grant  output  N_REQ  one-hot mirror of idx; all zeros when valid=0.
- valid  output  1  idx/grant hold a pending grant.
- ready  input  1  consumer accepts idx when valid&ready.
- pending  output  N_REQ  current sticky request register, excluding the bit being presented.
- coalesce_cnt  output  CNT_W  saturating count of requests that arrived while their bit was already pending or presented.

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=0, idx=0, grant=0, valid=0, rr pointer=0, coalesce_cnt=0. Reset has priority over all other activity, including mid-handshake; in-flight grants and pending bits are discarded.
- Handshake: hs = valid & ready. While valid=1 and ready=0, idx, grant and valid stay constant (no re-arbitration), even if a higher-priority request arrives.
- Candidate set: cand = pending | req. The presented bit is not in pending, so a re-request of it becomes a new pending entry.
- Load condition: the output register loads when valid=0 or hs=1.
  - On load: valid <= |cand; if nonzero, idx <= the first set bit of cand searched upward from ptr with wrap 15->0 (ptr treated as 0 when ROUND_ROBIN=0); grant <= 1<<idx.
  - The chosen bit is removed from pending; all other cand bits are written into pending.
- No load: pending <= pending | req.
- Pointer update: on hs, ptr <= idx+1 mod N_REQ, so idx 15 wraps to 0. ptr is unchanged otherwise.
- Latency: a req bit with an idle output appears on valid/idx after the next edge (1 cycle). Back-to-back grants are possible every cycle while ready=1.
- Coalescing: a req bit that is already set in pending, or that equals the presented idx while valid & !hs, increments coalesce_cnt by 1 per such bit per cycle (popcount). The counter saturates at 2**CNT_W-1 and never wraps.
- Simultaneous events: a req on the bit being accepted in that same cycle is a fresh request, is not coalesced, and is granted again later (set wins over clear).
- Empty: valid=0 and grant=0; idx holds its last value and is don't-care.
- Full: all 16 pending bits set; further requests only coalesce. No request is ever lost except across reset.

Decomposition:
- Shared package holds N_REQ, IDX_W, the one-hot/index conversion function, and the rotate-left helper. The existing decoder uses the same constants.
- One natural sub-module, rr_priority_pick: combinational rotating first-set search (cand, ptr -> found, any). Everything else (pending, output register, pointer, counter) stays in the top module.

Test Plan:
- Reset/idle: rst_n=0 two cycles with req=16'hFFFF -> after release, valid=0, pending=0, coalesce_cnt=0. The next req=16'h0008 for one cycle -> valid=1, idx=3, grant=16'h0008 one edge later.
- Round-robin order: req=16'h8421 for one cycle, ready=1 -> idx sequence 0, 5, 10, 15 on consecutive cycles, then valid=0. Repeating with ptr=6 gives 10, 15, 0, 5.
- Backpressure: valid with idx=2 and ready=0 for 5 cycles while req=16'h0001 pulses -> idx stays 2. After ready=1, the next grant is 0 (wrap from ptr=3) and coalesce_cnt is unchanged.
- Coalesce and saturation (CNT_W=8): hold req=16'h0010 with ready=0 for 300 cycles -> coalesce_cnt stops at 255 and pending[4]=1. Then ready=1 -> idx=4 is accepted, the pending bit is granted, and the final valid=0 once req is dropped.
- Set-wins: valid with idx=7, ready=1 and req[7]=1 in the same cycle -> the next cycle pending[7]=1 and idx=7 is granted again; coalesce_cnt is not incremented.
- Mid-operation reset: pending=16'h0F0F and valid=1, then rst_n=0 for one edge -> valid=0, pending=0. The next grant for req=16'h0100 is idx=8 (ptr back at 0).

Source files
------------

// File: rtl/onehot_request_encoder_pkg.sv
// Shared constants and helpers for the register-select encode/decode path.
//   IDX_W / N_REQ : selector width and number of one-hot lines (N_REQ = 2**IDX_W).
//   idx_to_onehot : index -> one-hot vector.
//   onehot_to_idx : one-hot vector -> index (input must have at most one bit set).
//   rotl          : rotate a request vector left by a selector-sized amount.
package onehot_request_encoder_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned N_REQ = 1 << IDX_W;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] rotl(input logic [N_REQ-1:0] x,
                                             input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] dbl;
    dbl = {x, x} << sh;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

endpackage

// File: rtl/onehot_request_encoder_rr_priority_pick.sv
// Combinational rotating first-set search.
//   cand  : candidate request vector.
//   ptr   : index where the upward search starts (wraps N_REQ-1 -> 0).
//   found : first set bit of cand at or after ptr; don't-care when any=0.
//   any   : cand has at least one bit set.
module rr_priority_pick
  import onehot_request_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] found,
  output logic             any
);

  logic [IDX_W-1:0] neg_ptr;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] lowest;

  // Rotating left by -ptr moves bit ptr down to position 0, so the lowest set
  // bit of rot is the first candidate at or above ptr.
  assign neg_ptr = '0 - ptr;
  assign rot     = rotl(cand, neg_ptr);
  assign lowest  = rot & (~rot + 1'b1);
  assign found   = ptr + onehot_to_idx(lowest);
  assign any     = |cand;

endmodule

// File: rtl/onehot_request_encoder.sv
// Collects one-hot request lines into a sticky pending set and presents one
// 4-bit index at a time over a valid/ready handshake.
//   clk, rst_n   : clock and synchronous active-low reset.
//   req          : request lines, any number set per cycle.
//   idx/grant    : presented index and its one-hot mirror (grant=0 when idle).
//   valid/ready  : handshake; the presented index is frozen while valid & !ready.
//   pending      : sticky requests not yet presented.
//   coalesce_cnt : saturating count of requests that hit an already-waiting bit.
module onehot_request_encoder
  import onehot_request_encoder_pkg::*;
#(
  parameter int unsigned N_REQ       = onehot_request_encoder_pkg::N_REQ,
  parameter int unsigned IDX_W       = onehot_request_encoder_pkg::IDX_W,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  input  logic             ready,
  output logic [N_REQ-1:0] pending,
  output logic [CNT_W-1:0] coalesce_cnt
);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hs, load, any;
  logic [N_REQ-1:0] cand, presented, coal;
  logic [IDX_W-1:0] search_ptr, found;
  logic [IDX_W:0]   coal_pc;
  logic [CNT_W:0]   cnt_sum;

  assign hs        = valid_q & ready;
  assign load      = ~valid_q | hs;
  assign cand      = pending_q | req;
  assign presented = valid_q ? idx_to_onehot(idx_q) : '0;

  // A re-request of the bit being accepted this cycle is fresh, not a duplicate.
  assign coal = req & (pending_q | (hs ? '0 : presented));

  // On an accept the search already starts past the accepted index.
  assign search_ptr = (ROUND_ROBIN == 0) ? '0 : (hs ? idx_q + 1'b1 : ptr_q);

  rr_priority_pick u_pick (
    .cand  (cand),
    .ptr   (search_ptr),
    .found (found),
    .any   (any)
  );

  always_comb begin
    coal_pc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      coal_pc = coal_pc + {{IDX_W{1'b0}}, coal[i]};
    end
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(coal_pc);
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    pending_d = pending_q | req;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    if (hs) begin
      ptr_d = idx_q + 1'b1;
    end
    if (load) begin
      valid_d   = any;
      pending_d = cand & ~(any ? idx_to_onehot(found) : '0);
      if (any) begin
        idx_d = found;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign idx          = idx_q;
  assign grant        = presented;
  assign valid        = valid_q;
  assign pending      = pending_q;
  assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_onehot_request_encoder.sv
module tb_onehot_request_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic        ready = 1'b0;
  logic [3:0]  idx;
  logic [15:0] grant;
  logic        valid;
  logic [15:0] pending;
  logic [7:0]  coalesce_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onehot_request_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .idx          (idx),
    .grant        (grant),
    .valid        (valid),
    .ready        (ready),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

  // Reference model: a set of waiting request numbers plus the presented one.
  bit m_pend[16];
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_cnt;

  task automatic model_step(input logic r, input logic [15:0] q, input logic rd);
    bit hs;
    int found;
    if (!r) begin
      foreach (m_pend[b]) m_pend[b] = 0;
      m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    hs = m_valid && rd;
    for (int b = 0; b < 16; b++) begin
      if (q[b] && (m_pend[b] || (m_valid && !hs && b == m_idx))) begin
        if (m_cnt < 255) m_cnt++;
      end
    end
    for (int b = 0; b < 16; b++) if (q[b]) m_pend[b] = 1;
    if (hs) m_ptr = (m_idx + 1) % 16;
    if (!m_valid || hs) begin
      found = -1;
      for (int k = 0; k < 16 && found < 0; k++) begin
        if (m_pend[(m_ptr + k) % 16]) found = (m_ptr + k) % 16;
      end
      m_valid = (found >= 0);
      if (found >= 0) begin
        m_idx = found;
        m_pend[found] = 0;
      end
    end
  endtask

  function automatic logic [15:0] model_pend_vec();
    logic [15:0] v;
    for (int b = 0; b < 16; b++) v[b] = m_pend[b];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    eg = m_valid ? (16'd1 << m_idx) : 16'd0;
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".pending"}, 32'(pending), 32'(model_pend_vec()));
    check({tag, ".cnt"}, 32'(coalesce_cnt), 32'(m_cnt));
    if (m_valid) check({tag, ".idx"}, 32'(idx), 32'(m_idx));
  endtask

  task automatic step(input logic r, input logic [15:0] q, input logic rd);
    rst_n = r;
    req   = q;
    ready = rd;
    @(posedge clk);
    model_step(r, q, rd);
    #1;
  endtask

  typedef struct packed {
    logic        rst_n;
    logic [15:0] req;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic [15:0] exp_pend;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[17];
  logic [15:0] rq;

  initial begin
    // Expected state after each edge.
    tbl[0]  = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[1]  = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[2]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[3]  = '{1'b1, 16'h8421, 1'b1, 1'b1, 4'd0,  16'h8420, 8'd0};
    tbl[4]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd5,  16'h8400, 8'd0};
    tbl[5]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd10, 16'h8000, 8'd0};
    tbl[6]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd15, 16'h0000, 8'd0};
    tbl[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[8]  = '{1'b1, 16'h0020, 1'b1, 1'b1, 4'd5,  16'h0000, 8'd0};
    tbl[9]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[10] = '{1'b1, 16'h8421, 1'b1, 1'b1, 4'd10, 16'h8021, 8'd0};
    tbl[11] = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd15, 16'h0021, 8'd0};
    tbl[12] = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h0020, 8'd0};
    tbl[13] = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd5,  16'h0000, 8'd0};
    tbl[14] = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 8'd0};
    tbl[15] = '{1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0000, 8'd0};
    tbl[16] = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 8'd0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].ready);
      check("tbl.valid", 32'(valid), 32'(tbl[i].exp_valid));
      check("tbl.pending", 32'(pending), 32'(tbl[i].exp_pend));
      check("tbl.cnt", 32'(coalesce_cnt), 32'(tbl[i].exp_cnt));
      check("tbl.grant", 32'(grant),
            32'(tbl[i].exp_valid ? (16'd1 << tbl[i].exp_idx) : 16'd0));
      if (tbl[i].exp_valid) check("tbl.idx", 32'(idx), 32'(tbl[i].exp_idx));
    end

    // Backpressure: idx 2 frozen while a lower-priority request arrives.
    step(1'b1, 16'h0004, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    check("bp.idx", 32'(idx), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h0000, 1'b0);
      check("bp.idx_hold", 32'(idx), 32'd2);
      check("bp.pending", 32'(pending), 32'h0001);
    end
    step(1'b1, 16'h0000, 1'b1);
    check("bp.wrap_idx", 32'(idx), 32'd0);
    check("bp.valid", 32'(valid), 32'd1);
    check("bp.cnt", 32'(coalesce_cnt), 32'd0);
    step(1'b1, 16'h0000, 1'b1);
    check("bp.idle", 32'(valid), 32'd0);

    // Coalesce saturation.
    for (int i = 0; i < 300; i++) step(1'b1, 16'h0010, 1'b0);
    check("sat.cnt", 32'(coalesce_cnt), 32'd255);
    check("sat.pending", 32'(pending), 32'h0010);
    check("sat.idx", 32'(idx), 32'd4);
    step(1'b1, 16'h0000, 1'b1);
    check("sat.regrant_idx", 32'(idx), 32'd4);
    check("sat.regrant_valid", 32'(valid), 32'd1);
    check("sat.pending_clr", 32'(pending), 32'h0000);
    step(1'b1, 16'h0000, 1'b1);
    check("sat.idle", 32'(valid), 32'd0);
    check("sat.cnt_hold", 32'(coalesce_cnt), 32'd255);

    // Set wins over clear on the accepted bit.
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0080, 1'b0);
    check("sw.idx", 32'(idx), 32'd7);
    step(1'b1, 16'h0280, 1'b1);
    check("sw.idx9", 32'(idx), 32'd9);
    check("sw.pending7", 32'(pending), 32'h0080);
    check("sw.cnt", 32'(coalesce_cnt), 32'd0);
    step(1'b1, 16'h0000, 1'b1);
    check("sw.regrant7", 32'(idx), 32'd7);
    check("sw.valid", 32'(valid), 32'd1);
    step(1'b1, 16'h0000, 1'b1);

    // Reset in the middle of activity.
    step(1'b1, 16'h1000, 1'b0);
    step(1'b1, 16'h0F0F, 1'b0);
    check("mr.pending", 32'(pending), 32'h0F0F);
    check("mr.valid", 32'(valid), 32'd1);
    step(1'b0, 16'h0000, 1'b1);
    check("mr.rst_valid", 32'(valid), 32'd0);
    check("mr.rst_pending", 32'(pending), 32'h0000);
    check("mr.rst_grant", 32'(grant), 32'h0000);
    step(1'b1, 16'h0100, 1'b0);
    check("mr.idx8", 32'(idx), 32'd8);
    step(1'b1, 16'h0000, 1'b1);
    check_model("mr");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rq = 16'h0000;
        1: rq = 16'd1 << $urandom_range(0, 15);
        2: rq = 16'($urandom) & 16'($urandom);
        default: rq = 16'($urandom);
      endcase
      step(($urandom_range(0, 199) != 0), rq, ($urandom_range(0, 2) != 0));
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
